// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: issues data-memory reads/writes over a req/ack bus,
// handles byte/half/word lanes, and stalls the pipeline while an access is in flight.
module mem_access_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] aluout_in,
    input  logic [31:0] writedata_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [1:0]  memsize_in,
    input  logic        memsigned_in,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic [4:0]  writereg_in,
    output logic [31:0] rdm,
    output logic [31:0] aluoutm,
    output logic        regwritem,
    output logic        memtoregm,
    output logic [4:0]  writeregm,
    output logic        stallm,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [31:0]      aluout_q;
    logic             regwrite_q;
    logic             memtoreg_q;
    logic [4:0]       writereg_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             we_q;
    logic [31:0]      rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic is_access, misaligned, start, ack_take, timeout_hit;

    // Size 2'b11 is handled as a word everywhere.
    function automatic logic [31:0] fmt_load(input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return d;
        endcase
    endfunction

    always_comb begin
        is_access   = memread_in | memwrite_in;
        misaligned  = (memsize_in == 2'b01 && aluout_in[0]) ||
                      (memsize_in[1] && aluout_in[1:0] != 2'b00);
        start       = (state_q == StIdle) && is_access && !misaligned;
        ack_take    = (state_q == StBus) && mem_ack && mem_req;
        timeout_hit = (state_q == StBus) && !ack_take && (cnt_q == TimeoutLast);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBus;
            StBus:   if (ack_take || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            bus_err    <= 1'b0;
            aluout_q   <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            writereg_q <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            bus_err <= timeout_hit;
            if (start) begin
                aluout_q   <= aluout_in;
                regwrite_q <= regwrite_in;
                memtoreg_q <= memtoreg_in;
                writereg_q <= writereg_in;
                size_q     <= memsize_in;
                signed_q   <= memsigned_in;
                we_q       <= memwrite_in;
                rd_q       <= '0;
                cnt_q      <= '0;
                mem_req    <= 1'b1;
                mem_we     <= memwrite_in;
                mem_addr   <= {aluout_in[31:2], 2'b00};
                if (!memwrite_in) begin
                    mem_be    <= 4'b1111;
                    mem_wdata <= writedata_in;
                end else begin
                    case (memsize_in)
                        2'b00: begin
                            mem_be    <= 4'b0001 << aluout_in[1:0];
                            mem_wdata <= {4{writedata_in[7:0]}};
                        end
                        2'b01: begin
                            mem_be    <= aluout_in[1] ? 4'b1100 : 4'b0011;
                            mem_wdata <= {2{writedata_in[15:0]}};
                        end
                        default: begin
                            mem_be    <= 4'b1111;
                            mem_wdata <= writedata_in;
                        end
                    endcase
                end
            end else if (state_q == StBus) begin
                cnt_q <= cnt_q + 1'b1;
                if (ack_take) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    rd_q    <= we_q ? 32'd0
                                    : fmt_load(size_q, signed_q, aluout_q[1:0], mem_rdata);
                end else if (timeout_hit) begin
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    regwrite_q <= 1'b0;
                end
            end
        end
    end

    // Outputs are forced to a bubble while reset is asserted so a stall drops at once.
    always_comb begin
        rdm       = '0;
        aluoutm   = '0;
        regwritem = 1'b0;
        memtoregm = 1'b0;
        writeregm = '0;
        stallm    = 1'b0;
        addr_err  = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (!is_access) begin
                        aluoutm   = aluout_in;
                        regwritem = regwrite_in;
                        memtoregm = memtoreg_in;
                        writeregm = writereg_in;
                    end else if (misaligned) begin
                        addr_err = 1'b1;
                    end else begin
                        stallm = 1'b1;
                    end
                end
                StBus: stallm = 1'b1;
                StDone: begin
                    rdm       = rd_q;
                    aluoutm   = aluout_q;
                    regwritem = regwrite_q;
                    memtoregm = memtoreg_q;
                    writeregm = writereg_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (built with TIMEOUT=4).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aluout_in, writedata_in, mem_rdata;
    logic        memread_in, memwrite_in, memsigned_in, regwrite_in, memtoreg_in, mem_ack;
    logic [1:0]  memsize_in;
    logic [4:0]  writereg_in;
    logic [31:0] rdm, aluoutm, mem_addr, mem_wdata;
    logic        regwritem, memtoregm, stallm, addr_err, bus_err, mem_req, mem_we;
    logic [4:0]  writeregm;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.CNT_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .aluout_in(aluout_in), .writedata_in(writedata_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in), .memsize_in(memsize_in),
        .memsigned_in(memsigned_in), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .writereg_in(writereg_in), .rdm(rdm), .aluoutm(aluoutm), .regwritem(regwritem),
        .memtoregm(memtoregm), .writeregm(writeregm), .stallm(stallm), .addr_err(addr_err),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic nop();
        memread_in = 0; memwrite_in = 0; memsize_in = 0; memsigned_in = 0;
        regwrite_in = 0; memtoreg_in = 0; writereg_in = 0; aluout_in = 0; writedata_in = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; nop(); mem_ack = 0; mem_rdata = 0;
        #3;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stallm); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", mem_be); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        checks++; if ({bus_err, addr_err, regwritem} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {bus_err, addr_err, regwritem}); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        regwrite_in = 1; writereg_in = 5; aluout_in = 32'h1234;
        @(negedge clk);
        checks++; if (regwritem !== 1'b1) begin errors++; $display("FAIL pass_regwrite got %b exp 1", regwritem); end
        checks++; if (writeregm !== 5'd5) begin errors++; $display("FAIL pass_writereg got %0d exp 5", writeregm); end
        checks++; if (aluoutm !== 32'h1234) begin errors++; $display("FAIL pass_aluout got %h exp 1234", aluoutm); end
        checks++; if ({stallm, mem_req, rdm} !== 34'h0) begin
            errors++; $display("FAIL pass_idle got stall=%b req=%b rdm=%h exp 0", stallm, mem_req, rdm); end
        @(posedge clk); #1; nop();
    endtask

    task automatic test_lb();
        int stalls = 0;
        memread_in = 1; memsize_in = 2'b00; memsigned_in = 1; aluout_in = 32'h103;
        regwrite_in = 1; memtoreg_in = 1; writereg_in = 7;
        @(negedge clk); if (stallm) stalls++;
        checks++; if (regwritem !== 1'b0) begin errors++; $display("FAIL lb_bubble got %b exp 0", regwritem); end
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'h80FF_FF7F;
        @(negedge clk); if (stallm) stalls++;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lb_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 100", mem_addr); end
        checks++; if ({mem_we, mem_be} !== 5'b01111) begin
            errors++; $display("FAIL lb_we_be got %b exp 01111", {mem_we, mem_be}); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk); if (stallm) stalls++;
        checks++; if (stalls !== 2) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 2", stalls); end
        checks++; if (rdm !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdm got %h exp ffffff80", rdm); end
        checks++; if ({regwritem, memtoregm, writeregm} !== {2'b11, 5'd7}) begin
            errors++; $display("FAIL lb_ctrl got %b exp 1100111", {regwritem, memtoregm, writeregm}); end
        checks++; if ({aluoutm, mem_req} !== {32'h103, 1'b0}) begin
            errors++; $display("FAIL lb_done got alu=%h req=%b exp 103/0", aluoutm, mem_req); end
        @(posedge clk); #1; nop();
    endtask

    task automatic test_sh();
        memwrite_in = 1; memsize_in = 2'b01; aluout_in = 32'h202; writedata_in = 32'hAAAA_BEEF;
        @(negedge clk);
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL sh_stall got %b exp 1", stallm); end
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        checks++; if ({mem_req, mem_we} !== 2'b11) begin
            errors++; $display("FAIL sh_req_we got %b exp 11", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %h exp 200", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", mem_be); end
        checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", mem_wdata); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        checks++; if ({rdm, regwritem, stallm} !== 34'h0) begin
            errors++; $display("FAIL sh_done got rdm=%h rw=%b st=%b exp 0", rdm, regwritem, stallm); end
        @(posedge clk); #1; nop();
    endtask

    task automatic test_lanes();
        logic        v_we   [5] = '{1, 0, 0, 0, 1};
        logic [1:0]  v_sz   [5] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        logic        v_sgn  [5] = '{0, 0, 1, 0, 1};
        logic [31:0] v_addr [5] = '{32'h001, 32'h502, 32'h500, 32'h600, 32'h003};
        logic [31:0] v_wd   [5] = '{32'h1234_56A5, 0, 0, 0, 32'h0000_00C3};
        logic [31:0] v_rd   [5] = '{0, 32'hBEEF_1234, 32'h1234_8001, 32'hCAFE_F00D, 0};
        logic [3:0]  e_be   [5] = '{4'b0010, 4'hF, 4'hF, 4'hF, 4'b1000};
        logic [31:0] e_wd   [5] = '{32'hA5A5_A5A5, 0, 0, 0, 32'hC3C3_C3C3};
        logic [31:0] e_rdm  [5] = '{0, 32'h0000_BEEF, 32'hFFFF_8001, 32'hCAFE_F00D, 0};
        for (int i = 0; i < 5; i++) begin
            memread_in = !v_we[i]; memwrite_in = v_we[i]; memsize_in = v_sz[i];
            memsigned_in = v_sgn[i]; aluout_in = v_addr[i]; writedata_in = v_wd[i];
            regwrite_in = !v_we[i]; memtoreg_in = !v_we[i]; writereg_in = 5'd9;
            @(posedge clk); #1; mem_ack = 1; mem_rdata = v_rd[i];
            @(negedge clk);
            checks++; if (mem_be !== e_be[i]) begin
                errors++; $display("FAIL lane%0d_be got %b exp %b", i, mem_be, e_be[i]); end
            if (v_we[i]) begin
                checks++; if (mem_wdata !== e_wd[i]) begin
                    errors++; $display("FAIL lane%0d_wdata got %h exp %h", i, mem_wdata, e_wd[i]); end
            end
            @(posedge clk); #1; mem_ack = 0;
            @(negedge clk);
            checks++; if (rdm !== e_rdm[i]) begin
                errors++; $display("FAIL lane%0d_rdm got %h exp %h", i, rdm, e_rdm[i]); end
            @(posedge clk); #1; nop();
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  v_sz   [2] = '{2'b10, 2'b01};
        logic [31:0] v_addr [2] = '{32'h101, 32'h203};
        for (int i = 0; i < 2; i++) begin
            memread_in = 1; memsize_in = v_sz[i]; aluout_in = v_addr[i]; regwrite_in = 1;
            @(negedge clk);
            checks++; if ({addr_err, stallm, regwritem, mem_req} !== 4'b1000) begin
                errors++; $display("FAIL misal%0d got err/st/rw/req=%b exp 1000", i,
                                   {addr_err, stallm, regwritem, mem_req}); end
            @(posedge clk); #1; nop();
            @(negedge clk);
            checks++; if ({addr_err, mem_req} !== 2'b00) begin
                errors++; $display("FAIL misal%0d_after got %b exp 00", i, {addr_err, mem_req}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int n = 0;
        memread_in = 1; memsize_in = 2'b10; aluout_in = 32'h300; regwrite_in = 1; writereg_in = 3;
        @(negedge clk);
        do begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            n++;
        end while (mem_req && n < 20);
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", req_cycles); end
        checks++; if ({bus_err, regwritem, stallm} !== 3'b100) begin
            errors++; $display("FAIL to_done got be/rw/st=%b exp 100", {bus_err, regwritem, stallm}); end
        @(posedge clk); #1; nop(); mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if ({bus_err, mem_req, stallm, rdm} !== 35'h0) begin
            errors++; $display("FAIL to_late_ack got be=%b req=%b st=%b rdm=%h exp 0",
                               bus_err, mem_req, stallm, rdm); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_late_req got %b exp 0", mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        memread_in = 1; memsize_in = 2'b10; aluout_in = 32'h400; regwrite_in = 1; writereg_in = 4;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b exp 1", mem_req); end
        #2; rst_n = 0; #1;
        checks++; if ({mem_req, stallm} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_drop got req/st=%b exp 00", {mem_req, stallm}); end
        @(posedge clk); #1; nop(); mem_ack = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        checks++; if ({mem_req, stallm, regwritem} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_ack got %b exp 000", {mem_req, stallm, regwritem}); end
        #2; rst_n = 1;
        @(posedge clk); #1; mem_ack = 0;
        memread_in = 1; memsize_in = 2'b10; aluout_in = 32'h404; regwrite_in = 1;
        memtoreg_in = 1; writereg_in = 6;
        @(negedge clk);
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL rst_next_stall got %b exp 1", stallm); end
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h404) begin errors++; $display("FAIL rst_next_addr got %h exp 404", mem_addr); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        checks++; if ({rdm, regwritem, writeregm} !== {32'h1234_5678, 1'b1, 5'd6}) begin
            errors++; $display("FAIL rst_next_done got rdm=%h rw=%b wr=%0d exp 12345678/1/6",
                               rdm, regwritem, writeregm); end
        @(posedge clk); #1; nop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_lanes();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
